// File: rtl/trellis_flag_arbiter.sv
// trellis_flag_arbiter: two-stage arbiter that thins the per-lane trellis flags.
// A flagged lane is dropped when a flagged neighbour within d = seq_length-1
// lanes has a lower energy, or the same energy and a lower index. The last d
// lanes of the previous valid frame are kept as history, so a flag near the
// start of a frame also competes with kept flags near the end of the last frame.
// Optional kept-flag statistics counter: define TRELLIS_FLAG_ARBITER_STATS_EN.
module trellis_flag_arbiter #(
   parameter int width                   = 16,
   parameter int num_of_trellis_patterns = 4,
   parameter int seq_length              = 3,
   parameter int ener_bitwidth           = 18,
   parameter int cnt_bitwidth            = 16
) (
   input  logic                                                          clk,
   input  logic                                                          rst,
   input  logic                                                          in_valid,
   input  logic [width-1:0][$clog2(2*num_of_trellis_patterns+1)-1:0]    in_flags,
   input  logic [width-1:0][ener_bitwidth-1:0]                           in_eners,
   output logic                                                          out_valid,
   output logic [width-1:0][$clog2(2*num_of_trellis_patterns+1)-1:0]    out_flags,
   input  logic                                                          stat_clear,
   output logic [cnt_bitwidth-1:0]                                       flag_count
);

   localparam int F = $clog2(2*num_of_trellis_patterns+1);
   localparam int D = seq_length - 1;

   logic                               r_s1_valid;
   logic [width-1:0][F-1:0]            r_s1_flags;
   logic [width-1:0][ener_bitwidth-1:0] r_s1_eners;
   logic [D-1:0][F-1:0]                r_hist_flags;
   logic [D-1:0][ener_bitwidth-1:0]    r_hist_eners;
   logic                               r_out_valid;
   logic [width-1:0][F-1:0]            r_out_flags;
   logic [width-1:0][F-1:0]            w_kept_flags;
   logic [width-1:0]                   w_keep;

   // Stage 1: capture the frame on in_valid, otherwise hold the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_flags <= '0;
         r_s1_eners <= '0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_flags <= in_flags;
            r_s1_eners <= in_eners;
         end
      end
   end

   // Arbitration: in-frame neighbours within D, then history lanes for the first D lanes.
   always_comb begin
      w_keep       = '0;
      w_kept_flags = '0;
      for (int i = 0; i < width; i++) begin
         w_keep[i] = (r_s1_flags[i] != '0);
         for (int j = 0; j < width; j++) begin
            if ((j != i) && (j <= i + D) && (i <= j + D) && (r_s1_flags[j] != '0)) begin
               if ((r_s1_eners[j] < r_s1_eners[i]) ||
                   ((r_s1_eners[j] == r_s1_eners[i]) && (j < i))) begin
                  w_keep[i] = 1'b0;
               end
            end
         end
         // History slot k sat at lane width-D+k, i.e. D-k+i lanes before lane i.
         for (int k = 0; k < D; k++) begin
            if ((i <= k) && (r_hist_flags[k] != '0) && (r_hist_eners[k] <= r_s1_eners[i])) begin
               w_keep[i] = 1'b0;
            end
         end
         w_kept_flags[i] = w_keep[i] ? r_s1_flags[i] : '0;
      end
   end

   // Stage 2: register the result and roll the history, only for valid frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_flags  <= '0;
         r_hist_flags <= '0;
         r_hist_eners <= '0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_flags <= w_kept_flags;
            for (int k = 0; k < D; k++) begin
               r_hist_flags[k] <= w_kept_flags[width-D+k];
               r_hist_eners[k] <= r_s1_eners[width-D+k];
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_flags = r_out_flags;

`ifdef TRELLIS_FLAG_ARBITER_STATS_EN
   // Sum is wide enough to hold a saturated count plus a full frame of kept lanes.
   localparam int SW = cnt_bitwidth + $clog2(width + 1);
   localparam logic [SW-1:0] CntMax = SW'({cnt_bitwidth{1'b1}});

   logic [SW-1:0]           w_pop;
   logic [SW-1:0]           w_sum;
   logic [cnt_bitwidth-1:0] r_cnt;

   // Count kept lanes in the frame currently presented on out_flags.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < width; i++) begin
         if (r_out_flags[i] != '0) begin
            w_pop = w_pop + SW'(1);
         end
      end
      w_sum = SW'(r_cnt) + w_pop;
   end

   // Saturating accumulate; clear (or reset) beats a coincident out_valid.
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         r_cnt <= '0;
      end else if (r_out_valid) begin
         r_cnt <= (w_sum > CntMax) ? {cnt_bitwidth{1'b1}} : w_sum[cnt_bitwidth-1:0];
      end
   end

   assign flag_count = r_cnt;
`else
   logic w_unused_stat_clear;
   assign w_unused_stat_clear = stat_clear;
   assign flag_count          = '0;
`endif

endmodule

// File: tb/tb_trellis_flag_arbiter.sv
// Directed bench for trellis_flag_arbiter (width 16, d = 2, 4-bit flags, 4-bit counter).
module tb_trellis_flag_arbiter;

   localparam int W  = 16;
   localparam int NP = 4;
   localparam int SL = 3;
   localparam int EB = 18;
   localparam int CB = 4;
   localparam int F  = 4;
`ifdef TRELLIS_FLAG_ARBITER_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 stat_clear;
   logic                 out_valid;
   logic [W-1:0][F-1:0]  in_flags;
   logic [W-1:0][F-1:0]  out_flags;
   logic [W-1:0][F-1:0]  exp_flags;
   logic [W-1:0][EB-1:0] in_eners;
   logic [CB-1:0]        flag_count;
   int                   n_tests = 0;
   int                   n_fail  = 0;

   always #5 clk = ~clk;

   trellis_flag_arbiter #(
      .width                  (W),
      .num_of_trellis_patterns(NP),
      .seq_length             (SL),
      .ener_bitwidth          (EB),
      .cnt_bitwidth           (CB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_flags  (in_flags),
      .in_eners  (in_eners),
      .out_valid (out_valid),
      .out_flags (out_flags),
      .stat_clear(stat_clear),
      .flag_count(flag_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_frame();
      in_flags  = '0;
      in_eners  = '0;
      exp_flags = '0;
   endtask

   task automatic lane(input int l, input int f, input int e);
      in_flags[l] = F'(f);
      in_eners[l] = EB'(e);
   endtask

   task automatic expk(input int l, input int f);
      exp_flags[l] = F'(f);
   endtask

   // Drive the prepared frame for one cycle, check it two cycles later, then idle a cycle.
   task automatic run_frame(input string tag);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_flags"}, 64'(out_flags), 64'(exp_flags));
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      stat_clear = 1'b0;
      clear_frame();
      repeat (2) @(negedge clk);
      check("reset_valid", 64'(out_valid), 64'(0));
      check("reset_flags", 64'(out_flags), 64'(0));
      check("reset_count", 64'(flag_count), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single flag: latency exactly two cycles, output holds through idle cycle.
      clear_frame(); lane(5, 3, 100); expk(5, 3);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("single_lat1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_flags", 64'(out_flags), 64'(exp_flags));
      @(negedge clk);
      check("single_drop", 64'(out_valid), 64'(0));
      check("single_hold", 64'(out_flags), 64'(exp_flags));

      // Lowest energy in a cluster wins.
      clear_frame(); lane(4, 1, 50); lane(5, 2, 20); lane(6, 3, 50); expk(5, 2);
      run_frame("cluster");

      // Equal energy: lower index wins.
      clear_frame(); lane(7, 4, 30); lane(8, 5, 30); expk(7, 4);
      run_frame("tie");

      // Distance 3 is out of reach, distance 2 is in reach.
      clear_frame(); lane(2, 1, 5); lane(5, 2, 1); lane(9, 3, 7); lane(11, 4, 3);
      expk(2, 1); expk(5, 2); expk(11, 4);
      run_frame("distance");

      // History: lane 15 kept at 10, then gap of invalid garbage, then lane 0 loses the tie.
      clear_frame(); lane(15, 6, 10); expk(15, 6);
      run_frame("histA");
      clear_frame(); lane(14, 1, 0); lane(15, 1, 0); lane(0, 9, 0);
      expk(15, 6);
      repeat (2) @(negedge clk);
      check("gap_valid", 64'(out_valid), 64'(0));
      check("gap_hold", 64'(out_flags), 64'(exp_flags));
      clear_frame(); lane(0, 7, 10); lane(1, 8, 9); expk(1, 8);
      run_frame("histB");

      // History lane with higher energy does not suppress.
      clear_frame(); lane(14, 1, 5); lane(15, 2, 1); expk(15, 2);
      run_frame("histC");
      clear_frame(); lane(1, 3, 0); expk(1, 3);
      run_frame("histD");

      // History lane 14 reaches lane 0 only, not lane 1.
      clear_frame(); lane(14, 1, 1); expk(14, 1);
      run_frame("histE");
      clear_frame(); lane(1, 2, 9); expk(1, 2);
      run_frame("histF");

      // Back-to-back frames.
      clear_frame(); lane(3, 5, 4);
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_lat", 64'(out_valid), 64'(0));
      clear_frame(); lane(3, 6, 4); lane(4, 7, 2);
      @(negedge clk);
      in_valid = 1'b0;
      exp_flags = '0; expk(3, 5);
      check("b2b_g_valid", 64'(out_valid), 64'(1));
      check("b2b_g_flags", 64'(out_flags), 64'(exp_flags));
      @(negedge clk);
      exp_flags = '0; expk(4, 7);
      check("b2b_h_valid", 64'(out_valid), 64'(1));
      check("b2b_h_flags", 64'(out_flags), 64'(exp_flags));
      @(negedge clk);
      check("b2b_drop", 64'(out_valid), 64'(0));

      // Reset with two frames in flight; history must be emptied too.
      clear_frame(); lane(15, 3, 1); expk(15, 3);
      run_frame("pre_rst");
      clear_frame(); lane(0, 1, 5);
      in_valid = 1'b1;
      @(negedge clk);
      lane(0, 2, 5);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      check("midrst_valid0", 64'(out_valid), 64'(0));
      check("midrst_flags0", 64'(out_flags), 64'(0));
      @(negedge clk);
      check("midrst_valid1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("midrst_valid2", 64'(out_valid), 64'(0));
      check("midrst_flags2", 64'(out_flags), 64'(0));
      clear_frame(); lane(0, 2, 5); expk(0, 2);
      run_frame("post_rst");

      // Statistics: reset beats stat_clear, accumulate, saturate, clear.
      rst = 1'b1; stat_clear = 1'b1;
      @(negedge clk);
      rst = 1'b0; stat_clear = 1'b0;
      check("cnt_rst_clr", 64'(flag_count), 64'(0));
      clear_frame(); lane(7, 1, 1);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("cnt_three", 64'(flag_count), 64'(STATS * 3));
      in_valid = 1'b1;
      repeat (20) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("cnt_sat", 64'(flag_count), 64'(STATS * 15));
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      check("cnt_clear", 64'(flag_count), 64'(0));
      // Clear coincident with out_valid wins.
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("cnt_cv_valid", 64'(out_valid), 64'(1));
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      check("cnt_clr_wins", 64'(flag_count), 64'(0));
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("cnt_one", 64'(flag_count), 64'(STATS));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
